// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit_serializer block: FSM state encoding and counter sizing.
package bit_serializer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Bit counter must hold 0..width without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_serializer_shreg.sv
// Loadable shift register; shift direction set by MSB_FIRST.
// With BIT_SERIALIZER_PARITY_EN it also latches the even parity of the loaded word.
module bit_serializer_shreg
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             head_o
`ifdef BIT_SERIALIZER_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  logic [WIDTH-1:0] sh_q, sh_d;

  // Load wins over shift so a back-to-back reload replaces the drained word.
  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sh_d = {sh_q[WIDTH-2:0], 1'b0};
      end else begin
        sh_d = {1'b0, sh_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign head_o = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

`ifdef BIT_SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load_i) begin
      par_q <= ^data_i;
    end
  end

  assign parity_o = par_q;
`endif

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter with valid/ready on both sides.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_hs, final_hs, load, shift, head;

  assign out_hs = out_valid_q & out_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic par_bit;
  assign final_hs = out_hs & (state_q == ST_PARITY);
`else
  assign final_hs = out_hs & (state_q == ST_SHIFT) & (cnt_q == LAST_IDX);
`endif

  // Combinational out_ready -> in_ready path lets frames run back-to-back.
  assign in_ready = ~reset & ((state_q == ST_IDLE) | final_hs);
  assign load     = in_valid & in_ready;
  assign shift    = out_hs & (state_q == ST_SHIFT);

  bit_serializer_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .data_i  (in_byte),
    .shift_i (shift),
    .head_o  (head)
`ifdef BIT_SERIALIZER_PARITY_EN
    ,
    .parity_o(par_bit)
`endif
  );

  // Next-state, counter and registered output flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (shift) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
`ifdef BIT_SERIALIZER_PARITY_EN
            state_d = ST_PARITY;
`else
            if (load) begin
              cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
`endif
          end
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (out_hs) begin
          if (load) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_valid_d = (state_d != ST_IDLE);
`ifdef BIT_SERIALIZER_PARITY_EN
    out_last_d  = (state_d == ST_PARITY);
`else
    out_last_d  = (state_d == ST_SHIFT) && (cnt_d == LAST_IDX);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifdef BIT_SERIALIZER_PARITY_EN
  assign out_bit = (state_q == ST_PARITY) ? par_bit : head;
`else
  assign out_bit = head;
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances share stimulus;
// expected bit streams come from a word-level model queued at each input handshake.
module tb_bit_serializer;

  localparam int unsigned W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_byte = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         ir0, ob0, ov0, ol0;
  logic         ir1, ob1, ov1, ol1;

  int           tests = 0;
  int           fails = 0;
  int           rmode = 0;
  beat_t        q0[$];
  beat_t        q1[$];
  logic [W-1:0] pend[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(ir0),
    .out_bit(ob0), .out_valid(ov0), .out_ready(out_ready), .out_last(ol0)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(ir1),
    .out_bit(ob1), .out_valid(ov1), .out_ready(out_ready), .out_last(ol1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: data bits in transmit order, then optional parity bit.
  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q0.push_back('{b: w[W-1-i], l: (i == W - 1) && !PAR});
      q1.push_back('{b: w[i],     l: (i == W - 1) && !PAR});
    end
    if (PAR) begin
      q0.push_back('{b: ^w, l: 1'b1});
      q1.push_back('{b: ^w, l: 1'b1});
    end
  endtask

  // Driver: presents pending words, shapes out_ready, records accepted words.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (pend.size() != 0) && !reset;
      if (pend.size() != 0) in_byte = pend[0];
      @(negedge clk);
      #1;
      if (!reset && in_valid && ir0) push_frame(pend.pop_front());
    end
  end

  // Monitor: compares every presented beat against the queue heads.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready0_rst", ir0, 1'b0);
      chk("out_valid0_rst", ov0, 1'b0);
      chk("out_valid1_rst", ov1, 1'b0);
    end else begin
      chk("out_valid0", ov0, q0.size() != 0);
      if (q0.size() != 0 && ov0) begin
        chk("out_bit0", ob0, q0[0].b);
        chk("out_last0", ol0, q0[0].l);
        if (out_ready) void'(q0.pop_front());
      end
      chk("out_valid1", ov1, q1.size() != 0);
      if (q1.size() != 0 && ov1) begin
        chk("out_bit1", ob1, q1[0].b);
        chk("out_last1", ol1, q1[0].l);
        if (out_ready) void'(q1.pop_front());
      end
      chk("in_ready0", ir0, q0.size() == 0);
      chk("in_ready1", ir1, q1.size() == 0);
    end
  end

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((pend.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < lim) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (pend.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", q0.size());
      pend.delete();
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
    #2;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid0", ov0, 1'b0);
    chk("rst_out_bit0", ob0, 1'b0);
    chk("rst_out_last0", ol0, 1'b0);
    chk("rst_in_ready0", ir0, 1'b0);
    chk("rst_out_valid1", ov1, 1'b0);
    chk("rst_out_bit1", ob1, 1'b0);
    chk("rst_out_last1", ol1, 1'b0);
    chk("rst_in_ready1", ir1, 1'b0);
    @(negedge clk);
    #3;
    reset = 1'b0;

    rmode = 0;
    pend.push_back(8'hA5);
    wait_idle(100);
    pend.push_back(8'h01);
    wait_idle(100);
    pend.push_back(8'h3C);
    pend.push_back(8'hC3);
    wait_idle(100);
    pend.push_back(8'h07);
    wait_idle(100);

    rmode = 1;
    pend.push_back(8'h81);
    wait_idle(100);

    rmode = 2;
    for (int i = 0; i < 40; i++) pend.push_back(W'($urandom));
    wait_idle(3000);

    rmode = 0;
    for (int i = 0; i < 10; i++) pend.push_back(W'($urandom));
    wait_idle(500);

    // Abort a frame after three bits, then send a fresh word.
    pend.push_back(8'h0F);
    n = 0;
    while (q0.size() == 0 || q0.size() > int'(W + PAR) - 3) begin
      @(negedge clk);
      #2;
      n++;
      if (n > 100) break;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_out_valid0", ov0, 1'b0);
    chk("abort_out_valid1", ov1, 1'b0);
    chk("abort_in_ready0", ir0, 1'b0);
    pend.delete();
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    pend.push_back(8'hFF);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
